// File: rtl/uart_mem_dump.sv
// Streams a range of 16-bit memory words out over the UART transmitter, high byte first.
// Define UART_MEM_DUMP_TERM_EN to append a 0xFF 0xFF end marker to every dump.
//
// state   | meaning
// IDLE    | waiting for start
// RD      | read address presented to mem
// LAT     | mem data valid, captured into word_q
// TX_HI   | waiting for tx_ready to send high byte
// GD_HI   | guard cycle after high-byte strobe
// TX_LO   | waiting for tx_ready to send low byte
// GD_LO   | guard cycle after low-byte strobe
// NEXT    | advance address / count or finish
// TERM_HI | waiting for tx_ready to send first 0xFF
// GD_TH   | guard after first 0xFF
// TERM_LO | waiting for tx_ready to send second 0xFF
// GD_TL   | guard after second 0xFF
// FIN     | pulse done, drop busy
module uart_mem_dump #(
  parameter int ADDR_WIDTH = 10,
  parameter int WCNT_WIDTH = 10
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [WCNT_WIDTH-1:0] word_count_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [15:0]           mem_rd_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_en_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_LAT, S_TX_HI, S_GD_HI, S_TX_LO, S_GD_LO, S_NEXT,
`ifdef UART_MEM_DUMP_TERM_EN
    S_TERM_HI, S_GD_TH, S_TERM_LO, S_GD_TL,
`endif
    S_FIN
  } state_e;

`ifdef UART_MEM_DUMP_TERM_EN
  localparam state_e S_END = S_TERM_HI;
`else
  localparam state_e S_END = S_FIN;
`endif

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] start_word_addr;
  logic [WCNT_WIDTH-1:0] rem_q;
  logic [15:0]           word_q;
  logic                  unused_addr_lsb;

  assign start_word_addr = {start_addr_i[ADDR_WIDTH-1:1], 1'b0};
  assign unused_addr_lsb = start_addr_i[0];
  // Wraps naturally at 2^ADDR_WIDTH.
  assign addr_d          = addr_q + ADDR_WIDTH'(2);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      word_q     <= '0;
      mem_addr_o <= '0;
      mem_rd_o   <= 1'b0;
      tx_data_o  <= '0;
      tx_en_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      tx_en_o <= 1'b0;
      done_o  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= start_word_addr;
            rem_q  <= word_count_i;
            busy_o <= 1'b1;
            if (word_count_i == '0) begin
              state_q <= S_END;
            end else begin
              mem_addr_o <= start_word_addr;
              mem_rd_o   <= 1'b1;
              state_q    <= S_RD;
            end
          end
        end
        S_RD:  state_q <= S_LAT;
        S_LAT: begin
          word_q   <= mem_rd_data_i;
          mem_rd_o <= 1'b0;
          state_q  <= S_TX_HI;
        end
        S_TX_HI: begin
          if (tx_ready_i) begin
            tx_en_o   <= 1'b1;
            tx_data_o <= word_q[15:8];
            state_q   <= S_GD_HI;
          end
        end
        S_GD_HI: state_q <= S_TX_LO;
        S_TX_LO: begin
          if (tx_ready_i) begin
            tx_en_o   <= 1'b1;
            tx_data_o <= word_q[7:0];
            state_q   <= S_GD_LO;
          end
        end
        S_GD_LO: state_q <= S_NEXT;
        S_NEXT: begin
          if (rem_q == WCNT_WIDTH'(1)) begin
            state_q <= S_END;
          end else begin
            addr_q     <= addr_d;
            rem_q      <= rem_q - WCNT_WIDTH'(1);
            mem_addr_o <= addr_d;
            mem_rd_o   <= 1'b1;
            state_q    <= S_RD;
          end
        end
`ifdef UART_MEM_DUMP_TERM_EN
        S_TERM_HI: begin
          if (tx_ready_i) begin
            tx_en_o   <= 1'b1;
            tx_data_o <= 8'hFF;
            state_q   <= S_GD_TH;
          end
        end
        S_GD_TH: state_q <= S_TERM_LO;
        S_TERM_LO: begin
          if (tx_ready_i) begin
            tx_en_o   <= 1'b1;
            tx_data_o <= 8'hFF;
            state_q   <= S_GD_TL;
          end
        end
        S_GD_TL: state_q <= S_FIN;
`endif
        S_FIN: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Scoreboard bench for uart_mem_dump: memory and UART models, expected bytes/addresses in queues.
module tb_uart_mem_dump;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  start_addr_i = '0;
  logic [9:0]  word_count_i = '0;
  logic [9:0]  mem_addr_o;
  logic        mem_rd_o;
  logic [15:0] mem_rd_data_i = '0;
  logic [7:0]  tx_data_o;
  logic        tx_en_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        done_o;

  uart_mem_dump dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .word_count_i (word_count_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_rd_data_i(mem_rd_data_i),
    .tx_data_o    (tx_data_o),
    .tx_en_o      (tx_en_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Memory model: one-cycle read latency.
  logic [15:0] mem [0:511];
  always @(posedge sys_clk) mem_rd_data_i <= mem[mem_addr_o[9:1]];

  // UART model: idle unless held off by ready_en or a post-strobe busy gap.
  logic ready_en = 1'b1;
  int   gap_len  = 0;
  int   gap_cnt  = 0;
  assign tx_ready_i = ready_en && (gap_cnt == 0);
  always @(posedge sys_clk) begin
    if (tx_en_o) gap_cnt <= gap_len;
    else if (gap_cnt > 0) gap_cnt <= gap_cnt - 1;
  end

  logic [7:0] exp_bytes [$];
  logic [9:0] exp_addrs [$];
  logic [7:0] last_exp = 8'h00;
  int         done_cnt = 0;
  logic       prev_rd  = 1'b0;

  always @(negedge sys_clk) begin
    if (tx_en_o) begin
      if (exp_bytes.size() == 0) chk("tx_extra", {24'h0, tx_data_o}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_bytes.pop_front()});
    end
    if (mem_rd_o && !prev_rd) begin
      if (exp_addrs.size() == 0) chk("rd_extra", {22'h0, mem_addr_o}, 32'hFFFF_FFFF);
      else chk("rd_addr", {22'h0, mem_addr_o}, {22'h0, exp_addrs.pop_front()});
    end
    prev_rd = mem_rd_o;
    if (done_o) done_cnt++;
  end

  task automatic push_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    last_exp = b;
  endtask

  task automatic push_word(input logic [9:0] a, input logic [15:0] w);
    exp_addrs.push_back(a);
    push_byte(w[15:8]);
    push_byte(w[7:0]);
  endtask

  task automatic push_term();
`ifdef UART_MEM_DUMP_TERM_EN
    push_byte(8'hFF);
    push_byte(8'hFF);
`endif
  endtask

  // Leaves the bench at #1 after edge 0 (cycle 1).
  task automatic do_start(input logic [9:0] a, input logic [9:0] n);
    @(posedge sys_clk); #1;
    start_i = 1'b1; start_addr_i = a; word_count_i = n;
    @(posedge sys_clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 3000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("done_seen", {31'h0, done_o}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
    end
  endtask

  initial begin
    int         n;
    logic       en_seen;
    logic       data_moved;
    logic [7:0] held;

    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0101 + 16'h0011);
    mem[10'h200 >> 1] = 16'h1234;
    mem[10'h202 >> 1] = 16'hABCD;
    mem[10'h100 >> 1] = 16'hC35A;
    mem[10'h300 >> 1] = 16'h1111;
    mem[10'h302 >> 1] = 16'h2222;
    mem[10'h304 >> 1] = 16'h3333;
    mem[10'h3FE >> 1] = 16'hBEEF;
    mem[0]            = 16'h0102;

    #23;
    chk("rst_mem_addr", {22'h0, mem_addr_o}, 32'h0);
    chk("rst_mem_rd",   {31'h0, mem_rd_o},   32'h0);
    chk("rst_tx_data",  {24'h0, tx_data_o},  32'h0);
    chk("rst_tx_en",    {31'h0, tx_en_o},    32'h0);
    chk("rst_busy",     {31'h0, busy_o},     32'h0);
    chk("rst_done",     {31'h0, done_o},     32'h0);
    rst_n = 1'b1;
    idle_cycles(3);

    // Basic two-word dump with first-strobe latency.
    gap_len = 0; done_cnt = 0;
    push_word(10'h200, 16'h1234);
    push_word(10'h202, 16'hABCD);
    push_term();
    do_start(10'h200, 10'd2);
    chk("c1_busy",   {31'h0, busy_o},   32'd1);
    chk("c1_mem_rd", {31'h0, mem_rd_o}, 32'd1);
    n = 0;
    while (!tx_en_o && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("first_tx_latency", n, 32'd3);
    wait_done();
    chk("basic_busy_low", {31'h0, busy_o}, 32'd0);
    idle_cycles(5);
    chk("basic_done_cnt", done_cnt, 32'd1);

    // Zero-length dump.
    gap_len = 2; done_cnt = 0;
    push_term();
    do_start(10'h200, 10'd0);
    chk("zero_busy", {31'h0, busy_o}, 32'd1);
`ifdef UART_MEM_DUMP_TERM_EN
    wait_done();
`else
    n = 0;
    while (!done_o && n < 20) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("zero_done_latency", n, 32'd1);
`endif
    idle_cycles(8);
    chk("zero_done_cnt", done_cnt, 32'd1);

    // Transmitter held off in TX_HI.
    gap_len = 0; done_cnt = 0;
    held = last_exp;
    ready_en = 1'b0;
    push_word(10'h100, 16'hC35A);
    push_term();
    do_start(10'h101, 10'd1);
    idle_cycles(2);
    en_seen = 1'b0; data_moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_en_o) en_seen = 1'b1;
      if (tx_data_o !== held) data_moved = 1'b1;
      @(posedge sys_clk); #1;
    end
    chk("hold_no_tx_en",   {31'h0, en_seen},    32'd0);
    chk("hold_data_still", {31'h0, data_moved}, 32'd0);
    ready_en = 1'b1;
    @(posedge sys_clk); #1;
    chk("hold_tx_en_after_ready", {31'h0, tx_en_o}, 32'd1);
    chk("hold_tx_data",           {24'h0, tx_data_o}, 32'hC3);
    wait_done();
    idle_cycles(5);
    chk("hold_done_cnt", done_cnt, 32'd1);

    // Start while busy is ignored.
    gap_len = 3; done_cnt = 0;
    push_word(10'h300, 16'h1111);
    push_word(10'h302, 16'h2222);
    push_word(10'h304, 16'h3333);
    push_term();
    do_start(10'h300, 10'd3);
    idle_cycles(5);
    start_i = 1'b1; start_addr_i = 10'h010; word_count_i = 10'd1;
    @(posedge sys_clk); #1;
    start_i = 1'b0;
    wait_done();
    idle_cycles(15);
    chk("overlap_done_cnt", done_cnt, 32'd1);
    chk("overlap_busy",     {31'h0, busy_o}, 32'd0);

    // Odd start address and wrap past the top.
    gap_len = 1; done_cnt = 0;
    push_word(10'h3FE, 16'hBEEF);
    push_word(10'h000, 16'h0102);
    push_term();
    do_start(10'h3FF, 10'd2);
    wait_done();
    idle_cycles(5);
    chk("wrap_done_cnt", done_cnt, 32'd1);

    // Reset between high and low byte, then a clean dump.
    gap_len = 0; done_cnt = 0;
    exp_addrs.push_back(10'h200);
    push_byte(8'h12);
    do_start(10'h200, 10'd1);
    n = 0;
    while (!tx_en_o && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("rst_mid_hi_seen", {31'h0, tx_en_o}, 32'd1);
    @(negedge sys_clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_mem_addr", {22'h0, mem_addr_o}, 32'h0);
    chk("rmid_mem_rd",   {31'h0, mem_rd_o},   32'h0);
    chk("rmid_tx_data",  {24'h0, tx_data_o},  32'h0);
    chk("rmid_tx_en",    {31'h0, tx_en_o},    32'h0);
    chk("rmid_busy",     {31'h0, busy_o},     32'h0);
    chk("rmid_done",     {31'h0, done_o},     32'h0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);
    chk("rmid_no_done", done_cnt, 32'd0);
    push_word(10'h202, 16'hABCD);
    push_term();
    do_start(10'h202, 10'd1);
    wait_done();
    idle_cycles(5);
    chk("rmid_done_cnt", done_cnt, 32'd1);

    chk("sb_bytes_left", exp_bytes.size(), 32'd0);
    chk("sb_addrs_left", exp_addrs.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
